bcd_operand_entry: RTL and testbench

//   Upstream operand-entry stage for the 2-digit BCD adder/7-segment display block.

---
 rtl/bcd_operand_entry_if.sv | 24 ++
 rtl/bcd_operand_entry.sv | 147 ++++++++++++++
 tb/tb_bcd_operand_entry.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/bcd_operand_entry_if.sv
// Operand-entry bus: switch bank, carry switch and raw key in; captured operands out.
interface bcd_operand_entry_if;
  logic [7:0] sw;
  logic       cin_sw;
  logic       key_n;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       operands_valid;
  logic       err;
  logic [1:0] state;

  // Drives the switches and key, observes the captured operands.
  modport master (
    output sw, cin_sw, key_n,
    input  a, b, cin, operands_valid, err, state
  );

  // The entry block itself.
  modport slave (
    input  sw, cin_sw, key_n,
    output a, b, cin, operands_valid, err, state
  );
endinterface

// File: rtl/bcd_operand_entry.sv
// Operand entry for the 2-digit BCD adder: synchronises and debounces a single
// pushbutton, then captures operand A, then operand B plus carry-in, one press each.
// Entries whose digits are not valid BCD are rejected and flagged on err.
module bcd_operand_entry #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                resetn,
  bcd_operand_entry_if.slave  bus
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_A = 2'b00,
    WAIT_B = 2'b01,
    READY  = 2'b10
  } state_t;

  function automatic logic is_bcd(input logic [7:0] v);
    return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
  endfunction

  logic          s1, s2;
  logic          stable;
  logic [CW-1:0] cnt;
  logic          press;
  logic          bcd_ok;

  state_t        state_q, state_nxt;
  logic [7:0]    a_q, a_nxt;
  logic [7:0]    b_q, b_nxt;
  logic          cin_q, cin_nxt;
  logic          vld_q, vld_nxt;
  logic          err_q, err_nxt;

  // Two-flop synchroniser; the raw key is used nowhere else.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= bus.key_n;
      s2 <= s1;
    end
  end

  // Accept a level change only after it has persisted; any bounce restarts the count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stable <= 1'b1;
      cnt    <= '0;
    end else if (s2 != stable) begin
      if (cnt == CNT_MAX) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else begin
      cnt <= '0;
    end
  end

  // One-cycle strobe on the cycle the debounced level falls; release yields nothing.
  assign press  = (s2 != stable) && !s2 && (cnt == CNT_MAX);
  assign bcd_ok = is_bcd(bus.sw);

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= WAIT_A;
    else         state_q <= state_nxt;
  end

  // Next state: advance on an accepted press; the unused encoding falls back to WAIT_A.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      WAIT_A:  if (press && bcd_ok) state_nxt = WAIT_B;
      WAIT_B:  if (press && bcd_ok) state_nxt = READY;
      READY:   if (press)           state_nxt = WAIT_A;
      default:                      state_nxt = WAIT_A;
    endcase
  end

  // Next output values: captures and flags change only on a press, otherwise hold.
  always_comb begin
    a_nxt   = a_q;
    b_nxt   = b_q;
    cin_nxt = cin_q;
    vld_nxt = vld_q;
    err_nxt = err_q;
    if (press) begin
      case (state_q)
        WAIT_A: begin
          if (bcd_ok) begin
            a_nxt   = bus.sw;
            err_nxt = 1'b0;
          end else begin
            err_nxt = 1'b1;
          end
        end
        WAIT_B: begin
          if (bcd_ok) begin
            b_nxt   = bus.sw;
            cin_nxt = bus.cin_sw;
            vld_nxt = 1'b1;
            err_nxt = 1'b0;
          end else begin
            err_nxt = 1'b1;
          end
        end
        READY: begin
          vld_nxt = 1'b0;
          err_nxt = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Output registers keep the adder inputs glitch-free.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_q   <= '0;
      b_q   <= '0;
      cin_q <= 1'b0;
      vld_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      a_q   <= a_nxt;
      b_q   <= b_nxt;
      cin_q <= cin_nxt;
      vld_q <= vld_nxt;
      err_q <= err_nxt;
    end
  end

  assign bus.a              = a_q;
  assign bus.b              = b_q;
  assign bus.cin            = cin_q;
  assign bus.operands_valid = vld_q;
  assign bus.err            = err_q;
  assign bus.state          = state_q;

endmodule

// File: tb/tb_bcd_operand_entry.sv
// Directed bench for bcd_operand_entry with DEBOUNCE_CYCLES=4.
module tb_bcd_operand_entry;

  logic clk;
  logic resetn;
  int   checks;
  int   errors;

  bcd_operand_entry_if bus ();

  bcd_operand_entry #(.DEBOUNCE_CYCLES(4)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] sw;
    logic       cin_sw;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       valid;
    logic       err;
    logic [1:0] st;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                         input logic ec, input logic ev, input logic ee, input logic [1:0] es);
    chk({tag, ".a"},     bus.a, ea);
    chk({tag, ".b"},     bus.b, eb);
    chk({tag, ".cin"},   8'(bus.cin), 8'(ec));
    chk({tag, ".valid"}, 8'(bus.operands_valid), 8'(ev));
    chk({tag, ".err"},   8'(bus.err), 8'(ee));
    chk({tag, ".state"}, 8'(bus.state), 8'(es));
  endtask

  // Full debounced press and release, returning at a falling edge.
  task automatic do_press(input logic [7:0] sw, input logic cin_sw);
    @(negedge clk);
    bus.sw     = sw;
    bus.cin_sw = cin_sw;
    bus.key_n  = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    bus.key_n = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic key_for(input logic lvl, input int n);
    @(negedge clk);
    bus.key_n = lvl;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    bus.sw     = 8'h00;
    bus.cin_sw = 1'b0;
    bus.key_n  = 1'b1;
    resetn     = 1'b1;

    vecs[0]  = '{8'h5A, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 2'b00};
    vecs[1]  = '{8'h99, 1'b0, 8'h99, 8'h00, 1'b0, 1'b0, 1'b0, 2'b01};
    vecs[2]  = '{8'hF9, 1'b0, 8'h99, 8'h00, 1'b0, 1'b0, 1'b1, 2'b01};
    vecs[3]  = '{8'h38, 1'b1, 8'h99, 8'h38, 1'b1, 1'b1, 1'b0, 2'b10};
    vecs[4]  = '{8'h5A, 1'b0, 8'h99, 8'h38, 1'b1, 1'b0, 1'b0, 2'b00};
    vecs[5]  = '{8'h0A, 1'b0, 8'h99, 8'h38, 1'b1, 1'b0, 1'b1, 2'b00};
    vecs[6]  = '{8'h47, 1'b0, 8'h47, 8'h38, 1'b1, 1'b0, 1'b0, 2'b01};
    vecs[7]  = '{8'h38, 1'b1, 8'h47, 8'h38, 1'b1, 1'b1, 1'b0, 2'b10};
    vecs[8]  = '{8'h00, 1'b1, 8'h47, 8'h38, 1'b1, 1'b0, 1'b0, 2'b00};
    vecs[9]  = '{8'h00, 1'b0, 8'h00, 8'h38, 1'b1, 1'b0, 1'b0, 2'b01};
    vecs[10] = '{8'h90, 1'b0, 8'h00, 8'h90, 1'b0, 1'b1, 1'b0, 2'b10};
    vecs[11] = '{8'h12, 1'b1, 8'h00, 8'h90, 1'b0, 1'b0, 1'b0, 2'b00};

    // Reset value, checked before any clock edge has occurred.
    #2 resetn = 1'b0;
    #1 chk_all("reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00);
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;

    // Table of press sequences from reset.
    for (int i = 0; i < 12; i++) begin
      do_press(vecs[i].sw, vecs[i].cin_sw);
      chk_all($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
              vecs[i].valid, vecs[i].err, vecs[i].st);
    end

    // Latency: capture lands on edge 6 of a held-low key, not edge 5.
    @(negedge clk);
    bus.sw    = 8'h47;
    bus.key_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("lat.edge5.a", bus.a, 8'h00);
    chk("lat.edge5.state", 8'(bus.state), 8'h00);
    @(posedge clk);
    #1;
    chk("lat.edge6.a", bus.a, 8'h47);
    chk("lat.edge6.state", 8'(bus.state), 8'h01);
    @(negedge clk);
    bus.sw = 8'h11;
    repeat (20) @(posedge clk);
    #1;
    chk_all("lat.hold", 8'h47, 8'h90, 1'b0, 1'b0, 1'b0, 2'b01);
    key_for(1'b1, 10);

    // Bounce: two 3-cycle low pulses never qualify.
    @(negedge clk);
    bus.sw     = 8'h38;
    bus.cin_sw = 1'b1;
    key_for(1'b0, 3);
    key_for(1'b1, 1);
    key_for(1'b0, 3);
    key_for(1'b1, 10);
    #1;
    chk_all("bounce", 8'h47, 8'h90, 1'b0, 1'b0, 1'b0, 2'b01);
    key_for(1'b0, 6);
    #1;
    chk_all("bounce.press", 8'h47, 8'h38, 1'b1, 1'b1, 1'b0, 2'b10);
    repeat (10) @(posedge clk);
    #1;
    chk("bounce.once.state", 8'(bus.state), 8'h02);
    key_for(1'b1, 10);

    // Asynchronous reset mid-run clears outputs without a clock edge.
    @(posedge clk);
    #3 resetn = 1'b0;
    #1 chk_all("areset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 2'b00);
    @(negedge clk);
    resetn = 1'b1;

    // Reset during a partial debounce aborts the press.
    @(negedge clk);
    bus.sw    = 8'h47;
    bus.key_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 resetn = 1'b0;
    @(negedge clk);
    bus.key_n = 1'b1;
    @(negedge clk);
    resetn = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("rstkey.noclap.state", 8'(bus.state), 8'h00);
    chk("rstkey.nocap.a", bus.a, 8'h00);

    // Key already low when reset releases: fresh press after 6 edges.
    @(negedge clk);
    resetn    = 1'b0;
    bus.key_n = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("heldlow.edge5.state", 8'(bus.state), 8'h00);
    @(posedge clk);
    #1;
    chk("heldlow.edge6.state", 8'(bus.state), 8'h01);
    chk("heldlow.edge6.a", bus.a, 8'h47);
    key_for(1'b1, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
